// File: rtl/conv_bram_arbiter_if.sv
// rtl/conv_bram_arbiter_if.sv - client and BRAM bus bundle for the conv membrane-potential arbiter
//
// Purpose: groups the three client handshakes (conv read, conv write-back,
// pool read with clear) and both BRAM port control sets into one bundle.
// Modports:
//   master - arbiter view: drives grants, read valids/data and all bram_* controls
//   slave  - environment view: drives requests and BRAM read data
interface conv_bram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();
    // conv read client
    logic                  conv_rd_req;
    logic [ADDR_WIDTH-1:0] conv_rd_addr;
    logic                  conv_rd_gnt;
    logic                  conv_rd_valid;
    logic [DATA_WIDTH-1:0] conv_rd_data;
    // conv write-back client
    logic                  conv_wr_req;
    logic [ADDR_WIDTH-1:0] conv_wr_addr;
    logic [DATA_WIDTH-1:0] conv_wr_data;
    logic                  conv_wr_gnt;
    // pool/readout client
    logic                  pool_rd_req;
    logic [ADDR_WIDTH-1:0] pool_rd_addr;
    logic                  pool_rd_clear;
    logic                  pool_rd_gnt;
    logic                  pool_rd_valid;
    logic [DATA_WIDTH-1:0] pool_rd_data;
    // BRAM side
    logic                  bram_clk;
    logic                  bram_rst_n;
    logic [ADDR_WIDTH-1:0] bram_addr_a;
    logic [DATA_WIDTH-1:0] bram_data_in_a;
    logic                  bram_we_a;
    logic                  bram_en_a;
    logic [DATA_WIDTH-1:0] bram_data_out_a;
    logic [ADDR_WIDTH-1:0] bram_addr_b;
    logic [DATA_WIDTH-1:0] bram_data_in_b;
    logic                  bram_we_b;
    logic                  bram_en_b;
    logic [DATA_WIDTH-1:0] bram_data_out_b;

    modport master (
        input  conv_rd_req, conv_rd_addr,
        output conv_rd_gnt, conv_rd_valid, conv_rd_data,
        input  conv_wr_req, conv_wr_addr, conv_wr_data,
        output conv_wr_gnt,
        input  pool_rd_req, pool_rd_addr, pool_rd_clear,
        output pool_rd_gnt, pool_rd_valid, pool_rd_data,
        output bram_clk, bram_rst_n,
        output bram_addr_a, bram_data_in_a, bram_we_a, bram_en_a,
        input  bram_data_out_a,
        output bram_addr_b, bram_data_in_b, bram_we_b, bram_en_b,
        input  bram_data_out_b
    );

    modport slave (
        output conv_rd_req, conv_rd_addr,
        input  conv_rd_gnt, conv_rd_valid, conv_rd_data,
        output conv_wr_req, conv_wr_addr, conv_wr_data,
        input  conv_wr_gnt,
        output pool_rd_req, pool_rd_addr, pool_rd_clear,
        input  pool_rd_gnt, pool_rd_valid, pool_rd_data,
        input  bram_clk, bram_rst_n,
        input  bram_addr_a, bram_data_in_a, bram_we_a, bram_en_a,
        output bram_data_out_a,
        input  bram_addr_b, bram_data_in_b, bram_we_b, bram_en_b,
        output bram_data_out_b
    );
endinterface

// File: rtl/conv_bram_arbiter.sv
// rtl/conv_bram_arbiter.sv - dual-port BRAM arbiter for conv read, conv write-back and pool read/clear
//
// Purpose: port A (read-only) is shared by conv read and pool read with a
// starvation guard for pool; port B (write-only) carries conv write-back or
// the zero write of a pool clear-after-read. Read data returns two cycles
// after grant; a same-cycle same-address port A read / port B write returns
// the written value.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - conv_bram_arbiter_if.master: client handshakes and BRAM controls
module conv_bram_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_bram_arbiter_if.master bus
);
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [0:0]      TAG_CONV   = 1'b0;
    localparam logic [0:0]      TAG_POOL   = 1'b1;

    // port A issue stage
    logic                  en_a_q,   en_a_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [0:0]            tag_a_q,  tag_a_d;
    // read return stage
    logic                  conv_vld_q, conv_vld_d;
    logic                  pool_vld_q, pool_vld_d;
    logic                  fwd_q,      fwd_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] conv_hold_q, conv_hold_d;
    logic [DATA_WIDTH-1:0] pool_hold_q, pool_hold_d;
    // port B issue stage
    logic                  en_b_q,   en_b_d;
    logic                  we_b_q,   we_b_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    // clear-after-read and starvation state
    logic                  clr_pend_q, clr_pend_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [SW-1:0]         starve_q,   starve_d;

    logic                  pool_wins;
    logic                  rd_gnt_any;
    logic [DATA_WIDTH-1:0] rd_ret_data;
    logic                  unused_ok;

    assign unused_ok = ^bus.bram_data_out_b;

    assign bus.bram_clk   = clk;
    assign bus.bram_rst_n = rst_n;

    // Pool takes port A when conv is idle, or once it has been denied
    // STARVE_LIMIT cycles in a row.
    assign pool_wins  = bus.pool_rd_req && (!bus.conv_rd_req || (starve_q == STARVE_MAX));
    assign rd_gnt_any = bus.conv_rd_req || bus.pool_rd_req;

    assign bus.pool_rd_gnt = pool_wins;
    assign bus.conv_rd_gnt = bus.conv_rd_req && !pool_wins;
    // Port B is reserved for the zero write the cycle after a clear-read grant.
    assign bus.conv_wr_gnt = !clr_pend_q;

    assign bus.bram_addr_a    = addr_a_q;
    assign bus.bram_en_a      = en_a_q;
    assign bus.bram_we_a      = 1'b0;
    assign bus.bram_data_in_a = '0;
    assign bus.bram_addr_b    = addr_b_q;
    assign bus.bram_data_in_b = data_b_q;
    assign bus.bram_we_b      = we_b_q;
    assign bus.bram_en_b      = en_b_q;

    // Forwarded data overrides the BRAM output regardless of its collision mode.
    assign rd_ret_data = fwd_q ? fwd_data_q : bus.bram_data_out_a;

    assign bus.conv_rd_valid = conv_vld_q;
    assign bus.pool_rd_valid = pool_vld_q;
    assign bus.conv_rd_data  = conv_vld_q ? rd_ret_data : conv_hold_q;
    assign bus.pool_rd_data  = pool_vld_q ? rd_ret_data : pool_hold_q;

    always_comb begin
        starve_d = '0;
        if (bus.pool_rd_req && !pool_wins) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end

        en_a_d   = rd_gnt_any;
        addr_a_d = addr_a_q;
        tag_a_d  = tag_a_q;
        if (rd_gnt_any) begin
            addr_a_d = pool_wins ? bus.pool_rd_addr : bus.conv_rd_addr;
            tag_a_d  = pool_wins ? TAG_POOL : TAG_CONV;
        end

        // BRAM captures the read during the cycle after issue; the tag and
        // any collision data travel alongside so valid lines up with data.
        conv_vld_d = en_a_q && (tag_a_q == TAG_CONV);
        pool_vld_d = en_a_q && (tag_a_q == TAG_POOL);
        fwd_d      = en_a_q && en_b_q && we_b_q && (addr_a_q == addr_b_q);
        fwd_data_d = fwd_d ? data_b_q : fwd_data_q;

        conv_hold_d = conv_vld_q ? rd_ret_data : conv_hold_q;
        pool_hold_d = pool_vld_q ? rd_ret_data : pool_hold_q;

        clr_pend_d = pool_wins && bus.pool_rd_clear;
        clr_addr_d = clr_pend_d ? bus.pool_rd_addr : clr_addr_q;

        en_b_d   = 1'b0;
        we_b_d   = 1'b0;
        addr_b_d = addr_b_q;
        data_b_d = data_b_q;
        if (clr_pend_q) begin
            en_b_d   = 1'b1;
            we_b_d   = 1'b1;
            addr_b_d = clr_addr_q;
            data_b_d = '0;
        end else if (bus.conv_wr_req) begin
            en_b_d   = 1'b1;
            we_b_d   = 1'b1;
            addr_b_d = bus.conv_wr_addr;
            data_b_d = bus.conv_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_a_q      <= 1'b0;
            addr_a_q    <= '0;
            tag_a_q     <= TAG_CONV;
            conv_vld_q  <= 1'b0;
            pool_vld_q  <= 1'b0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            conv_hold_q <= '0;
            pool_hold_q <= '0;
            en_b_q      <= 1'b0;
            we_b_q      <= 1'b0;
            addr_b_q    <= '0;
            data_b_q    <= '0;
            clr_pend_q  <= 1'b0;
            clr_addr_q  <= '0;
            starve_q    <= '0;
        end else begin
            en_a_q      <= en_a_d;
            addr_a_q    <= addr_a_d;
            tag_a_q     <= tag_a_d;
            conv_vld_q  <= conv_vld_d;
            pool_vld_q  <= pool_vld_d;
            fwd_q       <= fwd_d;
            fwd_data_q  <= fwd_data_d;
            conv_hold_q <= conv_hold_d;
            pool_hold_q <= pool_hold_d;
            en_b_q      <= en_b_d;
            we_b_q      <= we_b_d;
            addr_b_q    <= addr_b_d;
            data_b_q    <= data_b_d;
            clr_pend_q  <= clr_pend_d;
            clr_addr_q  <= clr_addr_d;
            starve_q    <= starve_d;
        end
    end
endmodule

// File: tb/tb_conv_bram_arbiter.sv
// tb/tb_conv_bram_arbiter.sv - directed self-checking bench for conv_bram_arbiter
module tb_conv_bram_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    conv_bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM model: port A registered read, port B write.
    assign bus.bram_data_out_b = '0;
    always @(posedge bus.bram_clk) begin
        if (bus.bram_en_a) bus.bram_data_out_a <= mem[bus.bram_addr_a];
        if (bus.bram_en_b && bus.bram_we_b) mem[bus.bram_addr_b] <= bus.bram_data_in_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic idle;
        bus.conv_rd_req   = 1'b0;
        bus.conv_rd_addr  = '0;
        bus.conv_wr_req   = 1'b0;
        bus.conv_wr_addr  = '0;
        bus.conv_wr_data  = '0;
        bus.pool_rd_req   = 1'b0;
        bus.pool_rd_addr  = '0;
        bus.pool_rd_clear = 1'b0;
    endtask

    task automatic read_conv(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        bus.conv_rd_req  = 1'b1;
        bus.conv_rd_addr = addr;
        smp();
        checks++;
        if (bus.conv_rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL %s_gnt got %0b want 1", name, bus.conv_rd_gnt);
        end
        tick();
        bus.conv_rd_req = 1'b0;
        tick();
        smp();
        checks++;
        if (bus.conv_rd_valid !== 1'b1 || bus.conv_rd_data !== exp) begin
            errors++;
            $display("FAIL %s got valid %0b data %h want valid 1 data %h", name, bus.conv_rd_valid, bus.conv_rd_data, exp);
        end
        tick();
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        smp();
        checks++;
        if (bus.bram_en_a !== 1'b0 || bus.bram_en_b !== 1'b0 || bus.bram_we_b !== 1'b0 ||
            bus.bram_addr_a !== '0 || bus.bram_addr_b !== '0 || bus.bram_data_in_b !== '0 ||
            bus.bram_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_bram got en_a %0b en_b %0b we_b %0b addr_a %h addr_b %h din_b %h rst %0b want all 0",
                     bus.bram_en_a, bus.bram_en_b, bus.bram_we_b, bus.bram_addr_a, bus.bram_addr_b,
                     bus.bram_data_in_b, bus.bram_rst_n);
        end
        checks++;
        if (bus.conv_rd_valid !== 1'b0 || bus.pool_rd_valid !== 1'b0 || bus.conv_wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_out got cv %0b pv %0b wr_gnt %0b want 0 0 1",
                     bus.conv_rd_valid, bus.pool_rd_valid, bus.conv_wr_gnt);
        end
        rst_n = 1'b1;
        tick();
        smp();
        checks++;
        if (bus.bram_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got bram_rst_n %0b want 1", bus.bram_rst_n);
        end
        tick();
    endtask

    task automatic test_conv_read;
        mem[5] = 32'h0000_00A5;
        bus.conv_rd_req  = 1'b1;
        bus.conv_rd_addr = 10'd5;
        smp();
        checks++;
        if (bus.conv_rd_gnt !== 1'b1 || bus.pool_rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cr_gnt got %0b/%0b want 1/0", bus.conv_rd_gnt, bus.pool_rd_gnt);
        end
        tick();
        bus.conv_rd_req = 1'b0;
        smp();
        checks++;
        if (bus.bram_en_a !== 1'b1 || bus.bram_addr_a !== 10'd5 || bus.bram_we_a !== 1'b0 ||
            bus.conv_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cr_issue got en %0b addr %0d we %0b valid %0b want 1 5 0 0",
                     bus.bram_en_a, bus.bram_addr_a, bus.bram_we_a, bus.conv_rd_valid);
        end
        tick();
        smp();
        checks++;
        if (bus.conv_rd_valid !== 1'b1 || bus.conv_rd_data !== 32'hA5 || bus.bram_en_a !== 1'b0) begin
            errors++;
            $display("FAIL cr_data got valid %0b data %h en_a %0b want 1 a5 0",
                     bus.conv_rd_valid, bus.conv_rd_data, bus.bram_en_a);
        end
        tick();
        smp();
        checks++;
        if (bus.conv_rd_valid !== 1'b0 || bus.conv_rd_data !== 32'hA5 || bus.pool_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cr_hold got valid %0b data %h pv %0b want 0 a5 0",
                     bus.conv_rd_valid, bus.conv_rd_data, bus.pool_rd_valid);
        end
        tick();
    endtask

    task automatic test_starvation;
        logic exp_pool;
        bus.conv_rd_req  = 1'b1;
        bus.conv_rd_addr = 10'd1;
        bus.pool_rd_req  = 1'b1;
        bus.pool_rd_addr = 10'd2;
        for (int c = 0; c < 18; c++) begin
            exp_pool = (c == 8) || (c == 17);
            smp();
            checks++;
            if (bus.pool_rd_gnt !== exp_pool || bus.conv_rd_gnt !== !exp_pool) begin
                errors++;
                $display("FAIL starve_c%0d got pool %0b conv %0b want pool %0b conv %0b",
                         c, bus.pool_rd_gnt, bus.conv_rd_gnt, exp_pool, !exp_pool);
            end
            tick();
        end
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_clear_after_read;
        mem[12] = 32'h0000_1234;
        bus.pool_rd_req   = 1'b1;
        bus.pool_rd_addr  = 10'd12;
        bus.pool_rd_clear = 1'b1;
        bus.conv_wr_req   = 1'b1;
        bus.conv_wr_addr  = 10'd20;
        bus.conv_wr_data  = 32'h99;
        smp();
        checks++;
        if (bus.pool_rd_gnt !== 1'b1 || bus.conv_wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL clr_t0 got pool %0b wr %0b want 1 1", bus.pool_rd_gnt, bus.conv_wr_gnt);
        end
        tick();
        bus.pool_rd_req   = 1'b0;
        bus.pool_rd_clear = 1'b0;
        smp();
        checks++;
        if (bus.conv_wr_gnt !== 1'b0 || bus.bram_en_b !== 1'b1 || bus.bram_addr_b !== 10'd20) begin
            errors++;
            $display("FAIL clr_t1 got wr_gnt %0b en_b %0b addr_b %0d want 0 1 20",
                     bus.conv_wr_gnt, bus.bram_en_b, bus.bram_addr_b);
        end
        tick();
        smp();
        checks++;
        if (bus.conv_wr_gnt !== 1'b1 || bus.pool_rd_valid !== 1'b1 || bus.pool_rd_data !== 32'h1234 ||
            bus.bram_we_b !== 1'b1 || bus.bram_addr_b !== 10'd12 || bus.bram_data_in_b !== '0) begin
            errors++;
            $display("FAIL clr_t2 got wr_gnt %0b pv %0b pd %h we_b %0b addr_b %0d din_b %h want 1 1 1234 1 12 0",
                     bus.conv_wr_gnt, bus.pool_rd_valid, bus.pool_rd_data, bus.bram_we_b,
                     bus.bram_addr_b, bus.bram_data_in_b);
        end
        tick();
        bus.conv_wr_req = 1'b0;
        smp();
        checks++;
        if (bus.pool_rd_valid !== 1'b0 || bus.pool_rd_data !== 32'h1234 || bus.conv_wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL clr_t3 got pv %0b pd %h wr_gnt %0b want 0 1234 1",
                     bus.pool_rd_valid, bus.pool_rd_data, bus.conv_wr_gnt);
        end
        tick();
        tick();
        read_conv(10'd12, 32'h0, "clr_reread");
        read_conv(10'd20, 32'h99, "clr_wr20");
    endtask

    task automatic test_collision;
        mem[7] = 32'h11;
        bus.conv_wr_req   = 1'b1;
        bus.conv_wr_addr  = 10'd7;
        bus.conv_wr_data  = 32'h55;
        bus.pool_rd_req   = 1'b1;
        bus.pool_rd_addr  = 10'd7;
        bus.pool_rd_clear = 1'b0;
        smp();
        checks++;
        if (bus.pool_rd_gnt !== 1'b1 || bus.conv_wr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL col_gnt got pool %0b wr %0b want 1 1", bus.pool_rd_gnt, bus.conv_wr_gnt);
        end
        tick();
        idle();
        tick();
        smp();
        checks++;
        if (bus.pool_rd_valid !== 1'b1 || bus.pool_rd_data !== 32'h55) begin
            errors++;
            $display("FAIL col_fwd got valid %0b data %h want 1 55", bus.pool_rd_valid, bus.pool_rd_data);
        end
        tick();
        read_conv(10'd7, 32'h55, "col_reread");
    endtask

    task automatic test_reset_midflight;
        bus.conv_rd_req  = 1'b1;
        bus.conv_rd_addr = 10'd5;
        bus.pool_rd_req  = 1'b1;
        bus.pool_rd_addr = 10'd3;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.bram_en_a !== 1'b0 || bus.bram_addr_a !== '0 || bus.bram_en_b !== 1'b0 ||
            bus.bram_we_b !== 1'b0 || bus.conv_rd_valid !== 1'b0 || bus.pool_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got en_a %0b addr_a %h en_b %0b we_b %0b cv %0b pv %0b want all 0",
                     bus.bram_en_a, bus.bram_addr_a, bus.bram_en_b, bus.bram_we_b,
                     bus.conv_rd_valid, bus.pool_rd_valid);
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            smp();
            checks++;
            if (bus.conv_rd_valid !== 1'b0 || bus.pool_rd_valid !== 1'b0 || bus.bram_en_a !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet_c%0d got cv %0b pv %0b en_a %0b want 0 0 0",
                         c, bus.conv_rd_valid, bus.pool_rd_valid, bus.bram_en_a);
            end
            tick();
        end
        // a cleared starve counter means pool waits the full 8 denied cycles again
        bus.conv_rd_req  = 1'b1;
        bus.conv_rd_addr = 10'd1;
        bus.pool_rd_req  = 1'b1;
        bus.pool_rd_addr = 10'd2;
        for (int c = 0; c < 9; c++) begin
            smp();
            checks++;
            if (bus.pool_rd_gnt !== (c == 8)) begin
                errors++;
                $display("FAIL rstmid_starve_c%0d got pool %0b want %0b", c, bus.pool_rd_gnt, (c == 8));
            end
            tick();
        end
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back_clear;
        logic exp_v;
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                bus.pool_rd_req   = 1'b1;
                bus.pool_rd_addr  = 10'(c);
                bus.pool_rd_clear = 1'b1;
            end else begin
                idle();
            end
            smp();
            if (c < 4) begin
                checks++;
                if (bus.pool_rd_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt_c%0d got %0b want 1", c, bus.pool_rd_gnt);
                end
            end
            exp_v = (c >= 2) && (c < 6);
            checks++;
            if (bus.pool_rd_valid !== exp_v || (exp_v && bus.pool_rd_data !== 32'(c - 1))) begin
                errors++;
                $display("FAIL b2b_rd_c%0d got valid %0b data %h want valid %0b data %h",
                         c, bus.pool_rd_valid, bus.pool_rd_data, exp_v, 32'(c - 1));
            end
            tick();
        end
        tick();
        for (int i = 0; i < 4; i++) read_conv(10'(i), 32'h0, "b2b_reread");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        bus.bram_data_out_a = '0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_conv_read();
        test_starvation();
        test_clear_after_read();
        test_collision();
        test_reset_midflight();
        test_back_to_back_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_bram_arbiter.md
Name: conv_bram_arbiter

Overview:
- Arbiter stage that drives the arbiter side of the team's dual-port BRAM interface for the convolution membrane-potential memory.
- Serves three clients:
  - convolution read
  - convolution write-back
  - pooling/readout read with optional clear-after-read
- Port A is read-only and port B is write-only.
- Resolves port contention, same-address collisions, and pooling starvation.

Parameters:
- DATA_WIDTH, 32, word width of the BRAM and all data ports.
- ADDR_WIDTH, 10, BRAM address width.
- STARVE_LIMIT, 8, consecutive denied pool-read cycles after which pool wins port A.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- conv_rd_req  in  1  conv read request
- conv_rd_addr  in  ADDR_WIDTH  conv read address
- conv_rd_gnt  out  1  conv read accepted this cycle
- conv_rd_valid  out  1  conv read data valid
- conv_rd_data  out  DATA_WIDTH  conv read data
- conv_wr_req  in  1  conv write request
- conv_wr_addr  in  ADDR_WIDTH  conv write address
- conv_wr_data  in  DATA_WIDTH  conv write data
- conv_wr_gnt  out  1  conv write accepted this cycle
- pool_rd_req  in  1  pool read request
- pool_rd_addr  in  ADDR_WIDTH  pool read address
- pool_rd_clear  in  1  zero the word after reading
- pool_rd_gnt  out  1  pool read accepted this cycle
- pool_rd_valid  out  1  pool read data valid
- pool_rd_data  out  DATA_WIDTH  pool read data
- bram_clk  out  1  equals clk
- bram_rst_n  out  1  equals rst_n
- bram_addr_a, bram_data_in_a, bram_we_a, bram_en_a  out  ADDR_WIDTH/DATA_WIDTH/1/1  port A controls
- bram_data_out_a  in  DATA_WIDTH  port A read data
- bram_addr_b, bram_data_in_b, bram_we_b, bram_en_b  out  ADDR_WIDTH/DATA_WIDTH/1/1  port B controls
- bram_data_out_b  in  DATA_WIDTH  unused

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst_n is asynchronous and active-low.
  - bram_clk and bram_rst_n are direct assigns of clk and rst_n.
- Reset values:
  - All bram_* registered outputs, valids, pipeline tags, clear-pending flag and starve counter are 0.
  - Reset mid-operation drops in-flight reads; no valid is emitted for them after release.
- Handshake:
  - A transfer occurs when req&&gnt.
  - Grants are combinational.
  - While gnt=0, a requester holds req and its fields stable.
- Port A arbitration (per cycle):
  - conv_rd wins over pool_rd unless starve_cnt==STARVE_LIMIT, in which case pool wins.
  - starve_cnt increments (saturating) each cycle pool_rd_req=1 and pool_rd_gnt=0.
  - starve_cnt clears on pool grant or pool_rd_req=0.
- Port A issue:
  - A granted read registers bram_en_a=1, bram_addr_a=addr and a source tag at the edge ending cycle t.
  - bram_we_a=0 and bram_data_in_a=0 always.
  - bram_en_a=0 in cycles with no grant.
- Read latency is fixed at 2 cycles:
  - BRAM captures at the edge ending t+1.
  - In t+2, the tagged source's *_rd_valid (registered) is high for one cycle.
  - *_rd_data = bram_data_out_a, or the forwarded value (see collision).
  - Non-tagged data output holds its last value.
- Clear-after-read:
  - A granted pool read with pool_rd_clear=1 sets clr_pend at the edge ending t.
  - In t+1 port B is reserved: conv_wr_gnt=0.
  - At the edge ending t+1, port B registers we_b=1, en_b=1, addr_b=pool addr, data_in_b=0.
  - Back-to-back clears (one per cycle) are legal.
- Port B issue otherwise:
  - conv_wr_gnt = !clr_pend.
  - A granted write registers we_b=en_b=1 with addr and data.
  - If not granted, we_b=en_b=0.
- Collision forwarding:
  - Applies when, in the same cycle, the registered port A read and port B write are both enabled to equal addresses.
  - The read's returned data is the port B write data (new value), captured alongside the tag.
  - This is independent of the BRAM's collision mode.
- Ordering: a read and a write to the same address issued by the arbiter in different cycles execute in issue order.

Test Plan:
- BRAM[5]=0xA5; conv_rd addr 5 in cycle t -> conv_rd_gnt=1 at t, bram_en_a=1/addr 5 at t+1, conv_rd_valid=1 with 0xA5 at t+2 only.
- conv_rd_req and pool_rd_req held high continuously, STARVE_LIMIT=8 -> pool granted on the 9th cycle, then conv resumes; pool grant pattern repeats every 9 cycles.
- BRAM[12]=0x1234; pool read-clear addr 12 with conv_wr_req held high -> pool_rd_data=0x1234, conv_wr_gnt=0 for exactly the one cycle after the pool grant, later read of 12 returns 0.
- conv_wr addr 7 data 0x55 and pool_rd addr 7 granted in the same cycle t (BRAM[7]=0x11) -> pool_rd_data=0x55 at t+2.
- Two reads in flight, rst_n pulsed low asynchronously -> all bram_* outputs 0 immediately, no rd_valid after release, starve_cnt=0.
- Pool read-clear addrs 0..3 in four consecutive cycles (values 1,2,3,4) -> four consecutive pool_rd_valid with 1,2,3,4; subsequent reads of 0..3 all return 0.
